// File: rtl/halt_controller.sv
// Debounced run/step buttons drive a HALTED/RUN/STEP FSM that freezes the clock divider.
// Optional step counter compiled in with `define HALT_CONTROLLER_STEP_COUNT_EN.
module halt_controller #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic        clockIn,
  input  logic        reset,
  input  logic        runButton,
  input  logic        stepButton,
  input  logic        slowClock,
  output logic        halt,
  output logic        running,
  output logic [15:0] stepCount
);

  typedef enum logic [1:0] {S_HALTED, S_RUN, S_STEP} state_t;

  // Channel 0 = run button, channel 1 = step button.
  logic [1:0]  w_btn;
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_deb;
  logic [1:0]  r_deb_prev;
  logic [19:0] r_cnt [2];
  logic [1:0]  w_press;
  logic        r_slow_prev;
  logic        w_slow_rise;
  logic        w_step_done;
  state_t      r_state;

  assign w_btn = {stepButton, runButton};

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_deb      <= '0;
      r_deb_prev <= '0;
      r_cnt[0]   <= '0;
      r_cnt[1]   <= '0;
    end else begin
      r_sync1    <= w_btn;
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 20'd1;
        end
      end
    end
  end

  assign w_press = r_deb & ~r_deb_prev;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_slow_prev <= 1'b0;
    end else begin
      r_slow_prev <= slowClock;
    end
  end

  assign w_slow_rise = slowClock & ~r_slow_prev;
  // A run press in STEP takes priority over completing the step.
  assign w_step_done = (r_state == S_STEP) && !w_press[0] && w_slow_rise;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_state <= S_HALTED;
    end else begin
      case (r_state)
        S_HALTED: begin
          if (w_press[0])      r_state <= S_RUN;
          else if (w_press[1]) r_state <= S_STEP;
        end
        S_RUN: begin
          if (w_press[0]) r_state <= S_HALTED;
        end
        S_STEP: begin
          if (w_press[0])       r_state <= S_RUN;
          else if (w_slow_rise) r_state <= S_HALTED;
        end
        default: r_state <= S_HALTED;
      endcase
    end
  end

  assign halt    = (r_state == S_HALTED);
  assign running = (r_state == S_RUN);

`ifdef HALT_CONTROLLER_STEP_COUNT_EN
  logic [15:0] r_step_count;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_step_count <= '0;
    end else if (w_step_done) begin
      r_step_count <= r_step_count + 16'd1;
    end
  end

  assign stepCount = r_step_count;
`else
  assign stepCount = 16'h0000;
`endif

endmodule

// File: tb/tb_halt_controller.sv
module tb_halt_controller;

  localparam int D = 4;
`ifdef HALT_CONTROLLER_STEP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clockIn;
  logic        reset;
  logic        runButton;
  logic        stepButton;
  logic        slowClock;
  logic        halt;
  logic        running;
  logic [15:0] stepCount;

  int checks = 0;
  int errors = 0;

  halt_controller #(.DEBOUNCE_CYCLES(20'd4)) dut (
    .clockIn(clockIn), .reset(reset), .runButton(runButton), .stepButton(stepButton),
    .slowClock(slowClock), .halt(halt), .running(running), .stepCount(stepCount)
  );

  initial begin
    clockIn = 1'b0;
    forever #5 clockIn = ~clockIn;
  end

  initial begin
    slowClock = 1'b0;
    forever begin
      repeat (3) @(negedge clockIn);
      slowClock = ~slowClock;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: modes 0=halted 1=run 2=step. Button samples are kept in a
  // queue; a level is accepted once D consecutive post-synchronizer samples
  // all disagree with the currently accepted level.
  int  m_state;
  logic [15:0] m_count;
  bit  runq[$];
  bit  stepq[$];
  bit  m_run_acc, m_step_acc;
  bit  m_run_pulse, m_step_pulse;
  bit  m_slow_prev;
  bit  force_active = 1'b0;

  function automatic bit accept_lvl(input bit q[$], input bit acc);
    int top;
    top = q.size() - 3;
    if (top - (D - 1) < 0) return 1'b0;
    for (int j = 0; j < D; j++)
      if (q[top - j] == acc) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clockIn or posedge reset) begin
    if (reset) begin
      m_state = 0; m_count = 16'h0;
      runq = {1'b0, 1'b0}; stepq = {1'b0, 1'b0};
      m_run_acc = 0; m_step_acc = 0; m_run_pulse = 0; m_step_pulse = 0;
      m_slow_prev = 0;
    end else begin
      bit rise;
      rise = slowClock && !m_slow_prev;
      case (m_state)
        0: if (m_run_pulse) m_state = 1; else if (m_step_pulse) m_state = 2;
        1: if (m_run_pulse) m_state = 0;
        default: begin
          if (m_run_pulse) m_state = 1;
          else if (rise) begin m_state = 0; m_count = m_count + 16'd1; end
        end
      endcase
      if (force_active) m_count = 16'hFFFF;
      m_slow_prev = slowClock;
      m_run_pulse = 0; m_step_pulse = 0;
      runq.push_back(runButton);
      stepq.push_back(stepButton);
      if (accept_lvl(runq, m_run_acc)) begin m_run_acc = !m_run_acc; m_run_pulse = m_run_acc; end
      if (accept_lvl(stepq, m_step_acc)) begin m_step_acc = !m_step_acc; m_step_pulse = m_step_acc; end
      if (runq.size() > D + 8) void'(runq.pop_front());
      if (stepq.size() > D + 8) void'(stepq.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clockIn);
    chk("halt", {15'd0, halt}, {15'd0, (m_state == 0)});
    chk("running", {15'd0, running}, {15'd0, (m_state == 1)});
    chk("stepCount", stepCount, CNT_EN ? m_count : 16'h0);
  endtask

  task automatic press_run();
    runButton = 1'b1; repeat (10) tick();
    runButton = 1'b0; repeat (10) tick();
  endtask

  task automatic do_step();
    stepButton = 1'b1; repeat (10) tick();
    stepButton = 1'b0; repeat (8) tick();
    for (int i = 0; i < 20 && !halt; i++) tick();
    chk("step_done_timeout", {15'd0, halt}, 16'd1);
  endtask

  initial begin
    runButton = 0; stepButton = 0; reset = 1'b1;
    #3;
    chk("rst_halt", {15'd0, halt}, 16'd1);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_count", stepCount, 16'd0);
    @(negedge clockIn); @(negedge clockIn);
    reset = 1'b0;

    // Idle after reset: nothing may move.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_halt", {15'd0, halt}, 16'd1);
    end

    // Short glitch must be rejected.
    runButton = 1'b1; repeat (3) tick();
    runButton = 1'b0; repeat (10) tick();
    chk("glitch_running", {15'd0, running}, 16'd0);

    // Held press reaches RUN exactly 2+D+1 cycles after the rise.
    runButton = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j <= 7) chk("press_latency", {15'd0, running}, {15'd0, (j == 7)});
    end
    runButton = 1'b0; repeat (10) tick();
    chk("run_held", {15'd0, running}, 16'd1);
    stepButton = 1'b1; repeat (10) tick();
    stepButton = 1'b0; repeat (10) tick();
    chk("run_ignores_step", {15'd0, running}, 16'd1);
    press_run();
    chk("run_to_halt", {15'd0, halt}, 16'd1);

    // Single steps.
    do_step();
    chk("step1_count", stepCount, CNT_EN ? 16'd1 : 16'd0);
    for (int s = 0; s < 3; s++) do_step();
    chk("step4_count", stepCount, CNT_EN ? 16'd4 : 16'd0);

    // Simultaneous press in HALTED goes to RUN.
    runButton = 1'b1; stepButton = 1'b1; repeat (10) tick();
    runButton = 1'b0; stepButton = 1'b0; repeat (10) tick();
    chk("simul_running", {15'd0, running}, 16'd1);
    chk("simul_count", stepCount, CNT_EN ? 16'd4 : 16'd0);
    press_run();

    // Counter wrap.
`ifdef HALT_CONTROLLER_STEP_COUNT_EN
    force_active = 1'b1;
    force dut.r_step_count = 16'hFFFF;
    @(negedge clockIn);
    release dut.r_step_count;
    force_active = 1'b0;
    tick();
    chk("forced_count", stepCount, 16'hFFFF);
`endif
    do_step();
    chk("wrap_count", stepCount, 16'h0);

    // Reset in the middle of a step.
    stepButton = 1'b1;
    for (int i = 0; i < 15 && halt; i++) tick();
    chk("enter_step", {15'd0, halt}, 16'd0);
    reset = 1'b1;
    #1;
    chk("midstep_rst_halt", {15'd0, halt}, 16'd1);
    chk("midstep_rst_count", stepCount, 16'd0);
    stepButton = 1'b0;
    @(negedge clockIn);
    runButton = 1'b1;
    @(negedge clockIn);
    reset = 1'b0;

    // Button held through reset release yields one press.
    repeat (12) tick();
    chk("held_thru_reset", {15'd0, running}, 16'd1);
    runButton = 1'b0; repeat (10) tick();
    chk("held_release", {15'd0, running}, 16'd1);

    // Random button activity including glitches, against the model.
    for (int n = 0; n < 120; n++) begin
      int sel, hold;
      sel  = $urandom_range(0, 3);
      hold = $urandom_range(1, 9);
      if (sel == 0 || sel == 2) runButton = ~runButton;
      if (sel == 1 || sel == 2) stepButton = ~stepButton;
      repeat (hold) tick();
    end
    runButton = 0; stepButton = 0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
